// File: rtl/i2592_event_monitor.sv
// Event monitor for the I2592 net: falling-edge event detection, windowed threshold alarm, saturating total count.
// Define I2592_MON_STICKY_EN to make the alarm sticky (cleared only by mon_clr or reset).
module i2592_event_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 4,
  parameter int unsigned WINDOW = 16
) (
  input  logic                     I1294_clk,
  input  logic                     I1301_rst,
  input  logic                     I2592,
  input  logic                     mon_en,
  input  logic                     mon_clr,
  input  logic                     alarm_ack,
  output logic                     alarm,
  output logic [CNT_W-1:0]         evt_total,
  output logic [$clog2(THRESH):0]  win_evt,
  output logic [1:0]               mon_state
);

  localparam int unsigned WC_W = $clog2(WINDOW) + 1;
  localparam int unsigned WE_W = $clog2(THRESH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              s_q;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]   win_evt_q, win_evt_d;
  logic [CNT_W-1:0]  evt_total_q, evt_total_d;
  logic              alarm_q, alarm_d;

  logic              evt_c;
  logic [WE_W:0]     win_sum_c;
  logic              trig_hit_c;
  logic              win_end_c;
  logic              trig_exit_c;

  // A held low level yields one event: only the high->low sample pair fires
  assign evt_c      = s_q & ~I2592;
  assign win_sum_c  = {1'b0, win_evt_q} + (WE_W+1)'(evt_c);
  assign trig_hit_c = win_sum_c >= (WE_W+1)'(THRESH);
  assign win_end_c  = win_cnt_q == WC_W'(WINDOW - 1);

`ifdef I2592_MON_STICKY_EN
  logic unused_alarm_ack;
  assign unused_alarm_ack = alarm_ack;
  assign trig_exit_c      = mon_clr;
`else
  assign trig_exit_c      = alarm_ack;
`endif

  always_ff @(posedge I1294_clk or negedge I1301_rst) begin
    if (!I1301_rst) begin
      state_q     <= ST_IDLE;
      s_q         <= 1'b1;
      win_cnt_q   <= '0;
      win_evt_q   <= '0;
      evt_total_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= I2592;
      win_cnt_q   <= win_cnt_d;
      win_evt_q   <= win_evt_d;
      evt_total_q <= evt_total_d;
      alarm_q     <= alarm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    win_evt_d   = win_evt_q;
    evt_total_d = evt_total_q;

    // Clear wins over a coincident event
    if (mon_clr) begin
      evt_total_d = '0;
    end else if (evt_c && mon_en && !(&evt_total_q)) begin
      evt_total_d = evt_total_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        win_cnt_d = '0;
        win_evt_d = '0;
        if (mon_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!mon_en) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          win_evt_d = '0;
        end else if (mon_clr) begin
          win_cnt_d = '0;
          win_evt_d = '0;
        end else if (trig_hit_c) begin
          state_d   = ST_TRIG;
          win_evt_d = WE_W'(win_sum_c);
        end else if (win_end_c) begin
          win_cnt_d = '0;
          win_evt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WC_W'(1);
          win_evt_d = WE_W'(win_sum_c);
        end
      end
      ST_TRIG: begin
        if (mon_clr) win_evt_d = '0;
        if (trig_exit_c) begin
          state_d   = mon_en ? ST_ARMED : ST_IDLE;
          win_cnt_d = '0;
          win_evt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
        win_evt_d = '0;
      end
    endcase

    alarm_d = (state_d == ST_TRIG);
  end

  assign alarm     = alarm_q;
  assign evt_total = evt_total_q;
  assign win_evt   = win_evt_q;
  assign mon_state = state_q;

endmodule

// File: doc/i2592_event_monitor.md
Name: i2592_event_monitor

Overview:
Downstream observation stage for the I2592 subcircuit output net. Samples the net and detects event pulses, where an event is a 1->0 transition of the active-low NAND output. Raises an alarm when THRESH events occur within a WINDOW-cycle observation window. Keeps a saturating total event count, which a host reads and acknowledges through a simple handshake.

Parameters:
CNT_W, 8, width of the total event counter; saturates at 2^CNT_W-1
THRESH, 4, number of events in one window that fires the trigger; legal range 1..WINDOW
WINDOW, 16, window length in cycles; window counter width = clog2(WINDOW)+1

Ports:
I1294_clk  input  1  single clock; all flops rise-edge
I1301_rst  input  1  asynchronous active-low reset
I2592  input  1  observed net from the upstream subcircuit; event = falling edge
mon_en  input  1  monitor enable, level
mon_clr  input  1  synchronous clear of evt_total and win_evt, one-cycle pulse
alarm_ack  input  1  host acknowledge of a pending trigger
alarm  output  1  trigger pending
evt_total  output  CNT_W  saturating count of all events seen while mon_en=1
win_evt  output  clog2(THRESH)+1  events counted in the current window
mon_state  output  2  FSM state: 0=IDLE, 1=ARMED, 2=TRIGGERED

Behaviour:
- Reset values (I1301_rst=0, asynchronous):
  - mon_state=IDLE; alarm=0; evt_total=0; win_evt=0; window counter=0.
  - Input sample register = 1, so the first low sample after reset counts as an event.
- Event detection:
  - I2592 is registered once into s_q.
  - evt = s_q & ~I2592.
  - A low level held on I2592 produces one event only.
  - Counters and FSM update on the edge after evt is asserted (1-cycle latency from the input edge).
- evt_total:
  - Increments on evt when mon_en=1, in any state.
  - Holds at all-ones (saturates).
  - Priority: reset > mon_clr > increment. An event in the same cycle as mon_clr is dropped.
- FSM:
  - IDLE:
    - mon_en=1 -> ARMED. Window counter=0, win_evt=0.
  - ARMED:
    - Window counter increments each cycle.
    - On evt, win_evt increments.
    - If win_evt+evt reaches THRESH -> TRIGGERED, alarm=1 next cycle. This takes priority over window expiry in the same cycle.
    - Otherwise, when the window counter reaches WINDOW-1: window counter=0 and win_evt=0. An event in the expiring cycle is not carried into the new window.
    - mon_en=0 -> IDLE next cycle; window counter and win_evt cleared. mon_en=0 has priority over a trigger in the same cycle.
  - TRIGGERED:
    - alarm=1; win_evt frozen; window counter frozen.
    - alarm_ack=1 -> alarm=0 next cycle. Then go to ARMED with a fresh window if mon_en=1, otherwise go to IDLE.
    - alarm_ack while not in TRIGGERED is ignored.
- mon_clr in ARMED also restarts the window. mon_clr in TRIGGERED does not clear alarm.
- Reset asserted mid-window or mid-alarm returns to IDLE immediately with all outputs at reset values.

Optional Feature:
- Macro: I2592_MON_STICKY_EN.
- Defined:
  - alarm is sticky; alarm_ack is ignored.
  - TRIGGERED exits only on mon_clr (to ARMED if mon_en=1, otherwise IDLE) or on reset.
- Undefined: behaviour as above, with alarm_ack-driven exit.

Test Plan:
- Reset: hold I1301_rst=0 for 3 cycles with I2592 toggling -> alarm=0, evt_total=0, mon_state=0 throughout. On release with mon_en=1 -> mon_state=1 after one edge.
- Threshold: mon_en=1; 4 falling edges on I2592 spaced 3 cycles apart (all within 16 cycles) -> mon_state=2 and alarm=1 one cycle after the 4th edge; evt_total=4. Then pulse alarm_ack -> alarm=0, mon_state=1.
- Window expiry: 3 edges, then I2592 held high for 20 cycles -> win_evt returns to 0 at cycle 16 of the window; no alarm; evt_total=3.
- Saturation: CNT_W=4, 20 edges with alarm_ack held high -> evt_total stops at 15. Same-cycle mon_clr and edge -> evt_total=0.
- Disable mid-window: 2 edges, then mon_en=0 -> mon_state=0 next cycle, win_evt=0. Re-enable: 2 more edges -> no alarm (fresh window).
- Sticky build (I2592_MON_STICKY_EN): trigger the alarm, then pulse alarm_ack -> alarm stays 1. Pulse mon_clr -> alarm=0, mon_state=1.
